// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  localparam logic [8:0] HALT_INSTR_DEFAULT = 9'h1FF;

  // Values of the decoder's BranchFlag select
  localparam logic FLAG_ZERO = 1'b0;
  localparam logic FLAG_NEG  = 1'b1;

endpackage

// File: rtl/branch_resolve.sv
// Combinational branch resolution: decides taken and computes the next PC.
import fetch_pkg::*;

module branch_resolve #(
  parameter int PC_W  = 10,
  parameter int OFF_W = 8
) (
  input  logic             abs_branch,
  input  logic             rel_branch,
  input  logic             branch_invert,
  input  logic             flag_sel,
  input  logic             z,
  input  logic             n,
  input  logic [PC_W-1:0]  pc,
  input  logic [PC_W-1:0]  abs_target,
  input  logic [OFF_W-1:0] rel_offset,
  output logic             taken,
  output logic [PC_W-1:0]  next_pc
);

  logic            flag_val;
  logic [PC_W-1:0] rel_ext;

  assign flag_val = (flag_sel == FLAG_NEG) ? n : z;
  assign taken    = (abs_branch | rel_branch) & (flag_val ^ branch_invert);
  assign rel_ext  = {{(PC_W-OFF_W){rel_offset[OFF_W-1]}}, rel_offset};

  // Absolute wins when both branch kinds are flagged; all sums wrap at 2^PC_W.
  always_comb begin
    next_pc = pc + PC_W'(1);
    if (taken) begin
      if (abs_branch) next_pc = abs_target;
      else            next_pc = pc + rel_ext;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// PC / fetch stage with IDLE-RUN-HALT program control and z/n flag registers.
// Optional branch statistics counters: define INSTR_FETCH_BRANCH_STATS_EN.
import fetch_pkg::*;

module instr_fetch #(
  parameter int                 PC_W       = 10,
  parameter int                 INSTR_W    = 9,
  parameter int                 OFF_W      = 8,
  parameter logic [PC_W-1:0]    START_ADDR = '0,
  parameter logic [INSTR_W-1:0] HALT_INSTR = HALT_INSTR_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stall,
  input  logic [INSTR_W-1:0] instr_in,
  output logic [PC_W-1:0]    instr_addr,
  input  logic               abs_branch,
  input  logic               rel_branch,
  input  logic               branch_invert,
  input  logic               branch_flag,
  input  logic [PC_W-1:0]    abs_target,
  input  logic [OFF_W-1:0]   rel_offset,
  input  logic               flag_we,
  input  logic               alu_zero,
  input  logic               alu_neg,
`ifdef INSTR_FETCH_BRANCH_STATS_EN
  output logic [15:0]        branch_count,
  output logic [15:0]        taken_count,
`endif
  output logic               taken,
  output logic               running,
  output logic               done
);

  fetch_state_t    state, state_next;
  logic [PC_W-1:0] pc, pc_next, br_next_pc;
  logic            z, z_next, n, n_next;
  logic            br_taken;

  branch_resolve #(.PC_W(PC_W), .OFF_W(OFF_W)) u_branch (
    .abs_branch    (abs_branch),
    .rel_branch    (rel_branch),
    .branch_invert (branch_invert),
    .flag_sel      (branch_flag),
    .z             (z),
    .n             (n),
    .pc            (pc),
    .abs_target    (abs_target),
    .rel_offset    (rel_offset),
    .taken         (br_taken),
    .next_pc       (br_next_pc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      pc    <= '0;
      z     <= 1'b0;
      n     <= 1'b0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      z     <= z_next;
      n     <= n_next;
    end
  end

  // Branches see the flags registered before this edge; flag_we affects later cycles only.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    z_next     = z;
    n_next     = n;
    taken      = 1'b0;
    case (state)
      IDLE, HALT: begin
        if (start) begin
          state_next = RUN;
          pc_next    = START_ADDR;
          z_next     = 1'b0;
          n_next     = 1'b0;
        end
      end
      RUN: begin
        if (!stall) begin
          if (instr_in == HALT_INSTR) begin
            state_next = HALT;
          end else begin
            taken   = br_taken;
            pc_next = br_next_pc;
            if (flag_we) begin
              z_next = alu_zero;
              n_next = alu_neg;
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign instr_addr = pc;
  assign running    = (state == RUN);
  assign done       = (state == HALT);

`ifdef INSTR_FETCH_BRANCH_STATS_EN
  logic branch_cycle, restart;

  assign branch_cycle = (state == RUN) & ~stall & (instr_in != HALT_INSTR) & (abs_branch | rel_branch);
  assign restart      = (state != RUN) & start;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      branch_count <= '0;
      taken_count  <= '0;
    end else if (restart) begin
      branch_count <= '0;
      taken_count  <= '0;
    end else begin
      if (branch_cycle && branch_count != 16'hFFFF) branch_count <= branch_count + 16'd1;
      if (taken && taken_count != 16'hFFFF)         taken_count  <= taken_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch (default parameters, START_ADDR=0).
module tb_instr_fetch;

  logic       clk, reset, start, stall;
  logic [8:0] instr_in;
  logic [9:0] instr_addr, abs_target;
  logic       abs_branch, rel_branch, branch_invert, branch_flag;
  logic [7:0] rel_offset;
  logic       flag_we, alu_zero, alu_neg;
  logic       taken, running, done;

  int compared = 0;
  int mismatched = 0;

  instr_fetch dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .stall         (stall),
    .instr_in      (instr_in),
    .instr_addr    (instr_addr),
    .abs_branch    (abs_branch),
    .rel_branch    (rel_branch),
    .branch_invert (branch_invert),
    .branch_flag   (branch_flag),
    .abs_target    (abs_target),
    .rel_offset    (rel_offset),
    .flag_we       (flag_we),
    .alu_zero      (alu_zero),
    .alu_neg       (alu_neg),
    .taken         (taken),
    .running       (running),
    .done          (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic no_branch();
    abs_branch = 0; rel_branch = 0; branch_invert = 0; branch_flag = 0;
    flag_we = 0; alu_zero = 0; alu_neg = 0; stall = 0;
  endtask

  initial begin
    reset = 1; start = 0; instr_in = 9'h000; abs_target = '0; rel_offset = '0;
    no_branch();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_addr", instr_addr, 0);
    chk("reset_running", running, 0);
    chk("reset_done", done, 0);
    chk("reset_taken", taken, 0);
    reset = 0;

    // taken forced low in IDLE even with a would-be-taken branch
    abs_branch = 1; branch_invert = 1; #1;
    chk("idle_taken", taken, 0);
    step();
    chk("idle_pc_hold", instr_addr, 0);
    no_branch();

    start = 1; step(); start = 0;
    chk("start_running", running, 1);
    chk("seq_pc0", instr_addr, 0);
    step(); chk("seq_pc1", instr_addr, 1);
    step(); chk("seq_pc2", instr_addr, 2);
    step(); chk("seq_pc3", instr_addr, 3);
    step(); step(); chk("seq_pc5", instr_addr, 5);

    // z <= 1 at pc 5, then rel -3 from pc 6 -> 3
    flag_we = 1; alu_zero = 1; step(); no_branch();
    chk("pc6", instr_addr, 6);
    rel_branch = 1; rel_offset = 8'hFD; #1;
    chk("rel_taken", taken, 1);
    step(); no_branch();
    chk("rel_target", instr_addr, 3);

    // abs on inverted negative flag (n=0)
    abs_branch = 1; branch_flag = 1; branch_invert = 1; abs_target = 10'h200; #1;
    chk("abs_taken", taken, 1);
    step(); no_branch();
    chk("abs_target", instr_addr, 10'h200);

    // clear z, then same-cycle flag write must not affect the branch
    flag_we = 1; alu_zero = 0; step(); no_branch();
    chk("pc201", instr_addr, 10'h201);
    flag_we = 1; alu_zero = 1; rel_branch = 1; rel_offset = 8'h10; #1;
    chk("same_cycle_taken", taken, 0);
    step(); no_branch();
    chk("same_cycle_pc", instr_addr, 10'h202);
    rel_branch = 1; rel_offset = 8'h10; #1;
    chk("next_cycle_taken", taken, 1);
    step(); no_branch();
    chk("next_cycle_pc", instr_addr, 10'h212);

    // wrap checks: abs to 3FF, +1 -> 0, -3 -> 3FD, +5 -> 2
    abs_branch = 1; abs_target = 10'h3FF; step(); no_branch();
    chk("pc3ff", instr_addr, 10'h3FF);
    step();
    chk("wrap_inc", instr_addr, 0);
    rel_branch = 1; rel_offset = 8'hFD; step(); no_branch();
    chk("wrap_back", instr_addr, 10'h3FD);
    rel_branch = 1; rel_offset = 8'h05; step(); no_branch();
    chk("wrap_fwd", instr_addr, 10'h002);

    // stall 3 cycles with flag_we and a branch pending
    stall = 1; flag_we = 1; alu_zero = 0; alu_neg = 1; rel_branch = 1; rel_offset = 8'h10; #1;
    chk("stall_taken", taken, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_pc", instr_addr, 10'h002);
    end
    no_branch();
    rel_branch = 1; rel_offset = 8'h10; #1;
    chk("post_stall_z", taken, 1);
    step(); no_branch();
    chk("post_stall_pc", instr_addr, 10'h012);
    rel_branch = 1; branch_flag = 1; rel_offset = 8'h10; #1;
    chk("post_stall_n", taken, 0);
    step(); no_branch();
    chk("post_stall_pc2", instr_addr, 10'h013);

    // halt
    instr_in = 9'h1FF; flag_we = 1; #1;
    chk("halt_taken", taken, 0);
    step(); no_branch();
    chk("halt_done", done, 1);
    chk("halt_running", running, 0);
    chk("halt_pc", instr_addr, 10'h013);
    abs_branch = 1; branch_invert = 1; abs_target = 10'h100; #1;
    chk("halt_taken_forced", taken, 0);
    step(); no_branch();
    chk("halt_pc_hold", instr_addr, 10'h013);
    instr_in = 9'h000;

    // restart clears flags (z was 1)
    start = 1; step(); start = 0;
    chk("restart_done", done, 0);
    chk("restart_running", running, 1);
    chk("restart_pc", instr_addr, 0);
    rel_branch = 1; rel_offset = 8'h10; #1;
    chk("restart_z_clear", taken, 0);
    no_branch();

    // start ignored in RUN
    start = 1; step(); start = 0;
    chk("start_in_run", instr_addr, 1);
    step();
    chk("pre_reset_pc", instr_addr, 2);

    // asynchronous reset mid-run
    #2 reset = 1; #1;
    chk("async_reset_pc", instr_addr, 0);
    chk("async_reset_running", running, 0);
    reset = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
